// File: rtl/spi_burst_controller.sv
// rtl/spi_burst_controller.sv - TX/RX FIFO burst feeder for spi_master; optional inter-word gap enabled by SPI_BURST_GAP_EN
module spi_burst_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  tx_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rx_empty,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic                  spi_start,
  input  logic                  spi_rx_done,
  input  logic [DATA_WIDTH-1:0] spi_rx_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef SPI_BURST_GAP_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STORE, S_GAP, S_FINISH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STORE, S_FINISH} state_t;
`endif

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]         tx_wptr, tx_rptr;
  logic [CW-1:0]         tx_count;
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]         rx_wptr, rx_rptr;
  logic [CW-1:0]         rx_count;

  logic                  tx_push, tx_pop, tx_empty;
  logic                  rx_push, rx_pop, rx_full;
  logic                  done_q, rx_edge;
  logic [DATA_WIDTH-1:0] rx_cap, tx_hold;

  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);

  // LOAD is only entered with data queued, so the FSM pop never underflows
  assign tx_push = wr_en && !tx_full;
  assign tx_pop  = (state == S_LOAD);
  assign rx_pop  = rd_en && !rx_empty;
  // a full RX FIFO still accepts the word when the host frees a slot in the same cycle
  assign rx_push = (state == S_STORE) && (!rx_full || rx_pop);
  // only the rising edge counts, so a level-style done flag completes one transfer
  assign rx_edge = spi_rx_done && !done_q;

  // head word is shown directly during LOAD, then held for the rest of the transfer
  assign spi_tx_data = (state == S_LOAD) ? tx_mem[tx_rptr] : tx_hold;

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= wr_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_cap;
  end

  // RX FIFO pointers, occupancy and registered host read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rx_pop;
      if (rx_pop) begin
        rd_data <= rx_mem[rx_rptr];
        rx_rptr <= rx_rptr + 1'b1;
      end
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // transfer bookkeeping: done-flag history, captured words, sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q   <= 1'b0;
      rx_cap   <= '0;
      tx_hold  <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= spi_rx_done;
      if (state == S_LOAD) tx_hold <= tx_mem[tx_rptr];
      if (state == S_WAIT && rx_edge) rx_cap <= spi_rx_data;
      if (state == S_STORE && rx_full && !rx_pop) overflow <= 1'b1;
    end
  end

`ifdef SPI_BURST_GAP_EN
  logic [GW-1:0] gap_cnt;

  // inter-word gap down-counter, armed on every STORE and counted out in GAP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (state == S_STORE) begin
      gap_cnt <= GW'(GAP_CYCLES - 1);
    end else if (state == S_GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end
`else
  logic unused_gap;
  assign unused_gap = |GAP_CYCLES;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next-state and decoded outputs
  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    spi_start  = 1'b0;
    case (state)
      S_IDLE:   if (start && !tx_empty) state_next = S_LOAD;
      S_LOAD: begin
        spi_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT:   if (rx_edge) state_next = S_STORE;
      S_STORE: begin
`ifdef SPI_BURST_GAP_EN
        if (!tx_empty) state_next = S_GAP;
`else
        if (!tx_empty) state_next = S_LOAD;
`endif
        else           state_next = S_FINISH;
      end
`ifdef SPI_BURST_GAP_EN
      S_GAP:    if (gap_cnt == '0) state_next = S_LOAD;
`endif
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_burst_controller.sv
// tb/tb_spi_burst_controller.sv - directed bench for spi_burst_controller with a model spi_master
module tb_spi_burst_controller;

`ifdef SPI_BURST_GAP_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       start = 1'b0;
  logic       spi_rx_done = 1'b0;
  logic [7:0] spi_rx_data = 8'h00;
  logic       tx_full, rd_valid, rx_empty, busy, done, overflow, spi_start;
  logic [7:0] rd_data, spi_tx_data;

  spi_burst_controller #(.DATA_WIDTH(8), .DEPTH(8), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rx_empty(rx_empty),
    .start(start), .busy(busy), .done(done), .overflow(overflow),
    .spi_tx_data(spi_tx_data), .spi_start(spi_start),
    .spi_rx_done(spi_rx_done), .spi_rx_data(spi_rx_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model master and monitor state
  int         cyc = 0, starts = 0, done_cnt = 0, t_done = 0;
  int         pend = 0, m_wait = 0, m_left = 0, m_hold = 1, rsp_idx = 0;
  logic       rx_empty_q = 1'b1;
  logic [7:0] rsp [64];
  logic [7:0] tx_seen [$];
  logic       ovf_seen [$];
  int         t_start [$], t_rise [$], t_fill [$];

  // master answers each spi_start three cycles later, holding rx_done for m_hold cycles
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      pend = 0; m_wait = 0; m_left = 0; spi_rx_done = 1'b0;
    end else begin
      if (spi_start) begin
        starts++; tx_seen.push_back(spi_tx_data); t_start.push_back(cyc);
        ovf_seen.push_back(overflow); pend++;
      end
      if (done) begin done_cnt++; t_done = cyc; end
      if (rx_empty_q && !rx_empty) t_fill.push_back(cyc);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) spi_rx_done = 1'b0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          spi_rx_done = 1'b1; spi_rx_data = rsp[rsp_idx]; rsp_idx++;
          pend--; m_left = m_hold; t_rise.push_back(cyc);
        end
      end else if (pend > 0) begin
        m_wait = 3;
      end
    end
    rx_empty_q = rx_empty;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check({name, "_rd_valid"}, rd_valid, 1'b1);
    check({name, "_rd_data"}, rd_data, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) tick();
    check({name, "_done_seen"}, done_cnt != d0, 1'b1);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(); tick(); reset = 1'b1; tick();
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    logic       st;
    logic       e_full;
    logic       e_empty;
    logic       e_busy;
    logic       e_rdv;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int sb, rb, fb, d0, s0;

    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[3+i] = '{1'b1, 8'(8'h10 + i), 1'b0, 1'b0, (i == 7), 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h18, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // reset state
    reset = 1'b0; tick();
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_spi_start", spi_start, 1'b0);
    check("rst_spi_tx_data", spi_tx_data, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b1; tick();

    // vector table: empty-read, empty-start, fill to DEPTH+1
    d0 = done_cnt; s0 = starts;
    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].wr; wr_data = vecs[i].wdata; rd_en = vecs[i].rd; start = vecs[i].st;
      tick();
      wr_en = 1'b0; rd_en = 1'b0; start = 1'b0;
      check($sformatf("vec%0d_tx_full", i), tx_full, vecs[i].e_full);
      check($sformatf("vec%0d_rx_empty", i), rx_empty, vecs[i].e_empty);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].e_rdv);
    end
    check("empty_start_no_spi_start", starts - s0, 0);
    check("empty_start_no_done", done_cnt - d0, 0);

    // burst of a full FIFO: exactly 8 words, in order
    sb = tx_seen.size();
    for (int k = 0; k < 8; k++) rsp[rsp_idx + k] = 8'(8'hA0 + k);
    pulse_start();
    wait_done("full", 1000);
    check("full_starts", starts - s0, 8);
    check("full_done_once", done_cnt - d0, 1);
    for (int k = 0; k < 8; k++) check($sformatf("full_tx%0d", k), tx_seen[sb+k], 8'(8'h10 + k));
    for (int k = 0; k < 8; k++) pop_check($sformatf("full_rx%0d", k), 8'(8'hA0 + k));
    check("full_rx_drained", rx_empty, 1'b1);
    check("full_no_overflow", overflow, 1'b0);

    // two-word burst with latency checks
    do_reset();
    sb = tx_seen.size(); rb = t_rise.size(); fb = t_fill.size(); d0 = done_cnt; s0 = starts;
    rsp[rsp_idx] = 8'hAD; rsp[rsp_idx + 1] = 8'h89;
    push(8'hB7); push(8'hFB);
    pulse_start();
    check("two_start_latency", spi_start, 1'b1);
    check("two_first_tx", spi_tx_data, 8'hB7);
    wait_done("two", 300);
    check("two_starts", starts - s0, 2);
    check("two_tx0", tx_seen[sb], 8'hB7);
    check("two_tx1", tx_seen[sb+1], 8'hFB);
    check("two_done_once", done_cnt - d0, 1);
    check("two_edge_to_rx", t_fill[fb] - t_rise[rb], 2);
    check("two_store_to_next_start", t_start[sb+1] - t_rise[rb], 2 + GAP);
    check("two_last_to_done", t_done - t_rise[rb+1], 2);
    pop_check("two_rx0", 8'hAD);
    pop_check("two_rx1", 8'h89);
    check("two_rx_drained", rx_empty, 1'b1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("two_empty_read", rd_valid, 1'b0);

    // rx_done held high for 20 cycles counts once
    m_hold = 20; s0 = starts; d0 = done_cnt;
    rsp[rsp_idx] = 8'h11; rsp[rsp_idx + 1] = 8'h22;
    push(8'h55); push(8'h66);
    pulse_start();
    wait_done("hold", 500);
    check("hold_starts", starts - s0, 2);
    check("hold_done_once", done_cnt - d0, 1);
    pop_check("hold_rx0", 8'h11);
    pop_check("hold_rx1", 8'h22);
    check("hold_one_each", rx_empty, 1'b1);
    m_hold = 1;
    repeat (25) tick();

    // ten-word burst refilled on the fly, no reads: overflow on the 9th word
    sb = tx_seen.size(); s0 = starts;
    for (int k = 0; k < 10; k++) rsp[rsp_idx + k] = 8'(8'hC0 + k);
    for (int k = 0; k < 8; k++) push(8'(8'h30 + k));
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 200 && tx_full; i++) tick();
      check($sformatf("ovf_refill%0d_room", k), tx_full, 1'b0);
      push(8'(8'h38 + k));
    end
    wait_done("ovf", 2000);
    check("ovf_starts", starts - s0, 10);
    check("ovf_tx8", tx_seen[sb+8], 8'h38);
    check("ovf_tx9", tx_seen[sb+9], 8'h39);
    check("ovf_clear_at_9th_start", ovf_seen[sb+8], 1'b0);
    check("ovf_set_at_10th_start", ovf_seen[sb+9], 1'b1);
    check("ovf_sticky", overflow, 1'b1);
    for (int k = 0; k < 8; k++) pop_check($sformatf("ovf_rx%0d", k), 8'(8'hC0 + k));
    check("ovf_rx_drained", rx_empty, 1'b1);
    check("ovf_still_sticky", overflow, 1'b1);

    // reset while waiting for the master aborts the burst
    s0 = starts;
    push(8'h71); push(8'h72);
    pulse_start();
    for (int i = 0; i < 50 && starts == s0; i++) tick();
    check("abort_reached_wait", busy, 1'b1);
    check("abort_tx_held", spi_tx_data, 8'h71);
    reset = 1'b0; #1;
    check("abort_busy", busy, 1'b0);
    check("abort_spi_start", spi_start, 1'b0);
    check("abort_spi_tx_data", spi_tx_data, 8'h00);
    check("abort_done", done, 1'b0);
    check("abort_overflow", overflow, 1'b0);
    check("abort_rd_data", rd_data, 8'h00);
    check("abort_rd_valid", rd_valid, 1'b0);
    check("abort_tx_full", tx_full, 1'b0);
    check("abort_rx_empty", rx_empty, 1'b1);
    tick(); tick();
    reset = 1'b1; tick();
    s0 = starts; d0 = done_cnt;
    pulse_start();
    repeat (10) tick();
    check("abort_queue_lost_no_start", starts - s0, 0);
    check("abort_queue_lost_no_done", done_cnt - d0, 0);
    check("abort_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_burst_controller.md
Name: spi_burst_controller

Overview:
- Upstream feeder for spi_master: buffers outgoing bytes in a TX FIFO.
- Hands bytes to the master one transfer at a time and waits for each transfer to complete.
- Collects each byte received from the master into an RX FIFO.
- Lets the host queue a multi-byte burst and read back the responses without servicing every byte individually.

Parameters:
DATA_WIDTH, 8, width of one SPI word
DEPTH, 8, entries per FIFO (TX and RX); power of two, >= 2
GAP_CYCLES, 4, idle clk cycles between words; used only when SPI_BURST_GAP_EN is defined

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-low; clears all state
wr_en  in  1  push wr_data into TX FIFO
wr_data  in  DATA_WIDTH  word to transmit
tx_full  out  1  TX FIFO full
rd_en  in  1  pop RX FIFO
rd_data  out  DATA_WIDTH  popped word, registered
rd_valid  out  1  rd_data valid; 1-cycle pulse, the cycle after an accepted rd_en
rx_empty  out  1  RX FIFO empty
start  in  1  begin burst (sampled in IDLE only)
busy  out  1  burst in progress
done  out  1  1-cycle pulse at burst end
overflow  out  1  sticky; an RX word was dropped because RX FIFO was full
spi_tx_data  out  DATA_WIDTH  word presented to spi_master, held stable for the whole transfer
spi_start  out  1  1-cycle pulse requesting one transfer
spi_rx_done  in  1  master receive-complete flag (level or pulse)
spi_rx_data  in  DATA_WIDTH  master received word

Behaviour:
- Reset (reset=0, async): both FIFOs emptied (pointers/counts 0), FSM to IDLE.
- Reset values of outputs:
  - spi_tx_data=0, spi_start=0, busy=0, done=0, overflow=0, rd_data=0, rd_valid=0
  - tx_full=0, rx_empty=1
- Reset mid-burst aborts immediately; queued TX data is lost.
- FIFOs:
  - Circular buffers; counts are $clog2(DEPTH)+1 bits; pointers wrap DEPTH-1 -> 0.
  - wr_en while tx_full: ignored, no state change.
  - rd_en while rx_empty: ignored, rd_valid stays 0.
  - Simultaneous host push and FSM pop on TX FIFO: both happen; count unchanged.
  - Same rule for simultaneous FSM push and host pop on RX FIFO.
- Completion detect: spi_rx_done is registered; completion = rising edge (done_q=0, spi_rx_done=1). A level held high counts once.
- FSM states:
  - IDLE: busy=0. If start=1 and TX FIFO not empty -> LOAD. start with TX FIFO empty: ignored, no done pulse.
  - LOAD: pop TX head into spi_tx_data; spi_start=1 for exactly this cycle -> WAIT.
  - WAIT: spi_tx_data held. On completion edge, capture spi_rx_data -> STORE.
  - STORE: push captured word into RX FIFO. If RX FIFO full (and no same-cycle host pop): drop word, set overflow=1.
    - TX FIFO not empty -> LOAD (or GAP if feature enabled).
    - TX FIFO empty -> FINISH.
  - FINISH: done=1 for one cycle -> IDLE.
- busy=1 in LOAD, WAIT, STORE, GAP, FINISH.
- start is ignored while busy.
- Words written during a burst are sent in that same burst if they arrive before the STORE that would otherwise find the TX FIFO empty.
- Latency:
  - start -> spi_start: 1 cycle.
  - Completion edge -> word visible in RX FIFO (rx_empty falls): 2 cycles.
  - Last STORE -> done: 1 cycle.
- overflow clears only on reset.

Optional Feature:
- Macro: SPI_BURST_GAP_EN.
- Defined:
  - STORE with TX FIFO not empty goes to state GAP.
  - GAP holds for GAP_CYCLES cycles (down-counter, width $clog2(GAP_CYCLES+1)), then -> LOAD.
  - Gives the slave time to reload its tx_data between words.
  - No gap after the last word.
- Undefined: GAP state and counter absent; STORE -> LOAD directly; GAP_CYCLES unused.

Test Plan:
- Reset then push 0xB7, 0xFB; pulse start; model master echoes 0xAD, 0x89 -> 2 spi_start pulses, spi_tx_data = 0xB7 then 0xFB, done pulse once, RX pops return 0xAD, 0x89 with rd_valid each.
- Push DEPTH+1 words -> tx_full=1 after 8th write, 9th write ignored; burst sends exactly 8 words, no write-pointer wrap corruption.
- Burst of 10 words (refilled during burst), no RX reads -> first 8 stored, overflow=1 after 9th completion, RX contents = first 8 responses.
- Assert reset=0 while in WAIT -> all outputs at reset values the same cycle; later start with empty TX FIFO -> no spi_start, no done.
- spi_rx_done held high 20 cycles -> exactly one word stored. With SPI_BURST_GAP_EN, GAP_CYCLES=4: 2-word burst -> exactly 4 cycles spent in GAP between STORE and the second spi_start.
